// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the core and the iterative MUL/DIV unit.
interface riscv_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data,
    output ready, busy, done, result
  );
endinterface

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide,
// one bit per cycle, with divide-by-zero and signed overflow short-circuited.
module riscv_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          reset,
  riscv_muldiv_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic            neg_a_q, neg_b_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand for MUL*, divisor for DIV*
  logic [PW-1:0]   acc_q;    // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0] cnt_q;

  // Accept-time decode: sign handling, magnitudes and special divide cases.
  logic            accept_c;
  logic            is_div_c, sgn_a_c, sgn_b_c, neg_a_c, neg_b_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic            div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0] special_val_c;

  always_comb begin
    accept_c   = bus.start && (state_q == IDLE || state_q == DONE);
    is_div_c   = bus.funct3[2];
    sgn_a_c    = is_div_c ? ~bus.funct3[0]
                          : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    sgn_b_c    = is_div_c ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    neg_a_c    = sgn_a_c && bus.rs1_data[XLEN-1];
    neg_b_c    = sgn_b_c && bus.rs2_data[XLEN-1];
    a_mag_c    = neg_a_c ? -bus.rs1_data : bus.rs1_data;
    b_mag_c    = neg_b_c ? -bus.rs2_data : bus.rs2_data;
    div_zero_c = is_div_c && (bus.rs2_data == '0);
    div_ovf_c  = is_div_c && ~bus.funct3[0] && (bus.rs1_data == MIN_NEG) &&
                 (bus.rs2_data == '1);
    special_c  = div_zero_c || div_ovf_c;
    if (div_zero_c) special_val_c = bus.funct3[1] ? bus.rs1_data : '1;
    else            special_val_c = bus.funct3[1] ? '0 : bus.rs1_data;
  end

  // One iteration of shift-add multiply or restoring divide.
  logic [XLEN:0]   mul_sum_c;
  logic [XLEN:0]   rem_sh_c, diff_c;
  logic [PW-1:0]   step_c;

  always_comb begin
    mul_sum_c = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh_c  = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
    diff_c    = rem_sh_c - {1'b0, opnd_q};
    step_c    = '0;
    if (!op_q[2]) begin
      step_c = {mul_sum_c, acc_q[XLEN-1:1]};
    end else if (diff_c[XLEN]) begin
      step_c = {rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_c = {diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign fix-up and final result selection.
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] quot_c, rem_c, fix_val_c;

  always_comb begin
    prod_c = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot_c = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_c  = neg_a_q ? -acc_q[PW-1:XLEN] : acc_q[PW-1:XLEN];
    if (op_q[2])                fix_val_c = op_q[1] ? rem_c : quot_c;
    else if (op_q[1:0] == 2'b00) fix_val_c = prod_c[XLEN-1:0];
    else                        fix_val_c = prod_c[PW-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = special_c ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        if (accept_c) state_d = special_c ? DONE : CALC;
        else          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      bus.result <= '0;
    end else if (accept_c) begin
      op_q    <= bus.funct3;
      neg_a_q <= neg_a_c;
      neg_b_q <= neg_b_c;
      opnd_q  <= is_div_c ? b_mag_c : a_mag_c;
      acc_q   <= {{XLEN{1'b0}}, (is_div_c ? a_mag_c : b_mag_c)};
      cnt_q   <= CNT_W'(XLEN - 1);
      if (special_c) bus.result <= special_val_c;
    end else if (state_q == CALC) begin
      acc_q <= step_c;
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (state_q == FIX) begin
      bus.result <= fix_val_c;
    end
  end

  // Status outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.ready <= (state_d == IDLE) || (state_d == DONE);
      bus.busy  <= (state_d == CALC) || (state_d == FIX);
      bus.done  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed-vector bench for riscv_muldiv at XLEN=32 and XLEN=8.
module tb_riscv_muldiv;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  riscv_muldiv_if #(.XLEN(32)) b32 ();
  riscv_muldiv_if #(.XLEN(8))  b8 ();

  riscv_muldiv #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  riscv_muldiv #(.XLEN(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present an op at the current negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    b32.start    = 1'b1;
    b32.funct3   = f;
    b32.rs1_data = a;
    b32.rs2_data = b;
    @(posedge clk);
    @(negedge clk);
    b32.start    = 1'b0;
    b32.rs1_data = $urandom;
    b32.rs2_data = $urandom;
  endtask

  // Count cycles from acceptance until done; optionally poke start while busy.
  task automatic wait_done(input bit poke, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!b32.done && lat < 200) begin
      if (b32.busy) bcnt++;
      if (poke && b32.busy) begin
        b32.start  = lat[0];
        b32.funct3 = 3'b000;
      end
      @(negedge clk);
      lat++;
    end
    b32.start = 1'b0;
  endtask

  task automatic run8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input string name);
    int lat;
    b8.start    = 1'b1;
    b8.funct3   = f;
    b8.rs1_data = a;
    b8.rs2_data = b;
    @(posedge clk);
    @(negedge clk);
    b8.start    = 1'b0;
    b8.rs1_data = 8'hA5;
    b8.rs2_data = 8'h5A;
    lat = 1;
    while (!b8.done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd10);
    check({name, " result"}, 64'(b8.result), 64'(exp));
    @(negedge clk);
  endtask

  initial begin
    int lat, bcnt, ndone;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
    vecs[8]  = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[9]  = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
    vecs[10] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
    vecs[11] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
    vecs[12] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[15] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

    b32.start = 1'b0; b32.funct3 = 3'b000; b32.rs1_data = '0; b32.rs2_data = '0;
    b8.start  = 1'b0; b8.funct3  = 3'b000; b8.rs1_data  = '0; b8.rs2_data  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset ready",  64'(b32.ready),  64'd1);
    check("reset busy",   64'(b32.busy),   64'd0);
    check("reset done",   64'(b32.done),   64'd0);
    check("reset result", 64'(b32.result), 64'd0);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(1'b0, lat, bcnt);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d busy cycles", i), 64'(bcnt), 64'(vecs[i].lat - 1));
      check($sformatf("v%0d result", i), 64'(b32.result), 64'(vecs[i].exp));
      @(negedge clk);
      check($sformatf("v%0d done pulse", i), 64'(b32.done), 64'd0);
      check($sformatf("v%0d result held", i), 64'(b32.result), 64'(vecs[i].exp));
    end

    // Start pokes during CALC are ignored; then back-to-back accept from DONE.
    issue(3'b101, 32'd100, 32'd7);
    wait_done(1'b1, lat, bcnt);
    check("b2b first latency", 64'(lat), 64'd34);
    check("b2b first result", 64'(b32.result), 64'd14);
    issue(3'b000, 32'd3, 32'd4);
    check("b2b no bubble busy", 64'(b32.busy), 64'd1);
    check("b2b result stable", 64'(b32.result), 64'd14);
    wait_done(1'b0, lat, bcnt);
    check("b2b second latency", 64'(lat), 64'd34);
    check("b2b second result", 64'(b32.result), 64'd12);
    @(negedge clk);

    // Asynchronous reset in the middle of a divide aborts it.
    issue(3'b100, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("pre-reset busy", 64'(b32.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort ready",  64'(b32.ready),  64'd1);
    check("abort busy",   64'(b32.busy),   64'd0);
    check("abort done",   64'(b32.done),   64'd0);
    check("abort result", 64'(b32.result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    issue(3'b000, 32'd2, 32'd3);
    wait_done(1'b0, lat, bcnt);
    check("post-reset latency", 64'(lat), 64'd34);
    check("post-reset result", 64'(b32.result), 64'd6);
    @(negedge clk);

    // Narrow instance.
    run8(3'b000, 8'h0F, 8'h0F, 8'hE1, "x8 MUL");
    run8(3'b011, 8'h0F, 8'h0F, 8'h00, "x8 MULHU");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
